// File: rtl/velocity_control_pkg.sv
// Shared types and defaults for the velocity-control reset sequencer.
// RESET_SEQ_FAULT_LATCH_EN adds the latched FAULT state to the sequencer enum.
package velocity_control_pkg;

    localparam int DIV_DEFAULT        = 2000;
    localparam int HOLD_TICKS_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HOLD
`ifdef RESET_SEQ_FAULT_LATCH_EN
        ,
        FAULT
`endif
    } seq_state_t;

endpackage

// File: rtl/velocity_control_enable_gen.sv
// Phase counter and registered clock-enable strobe, high for one cycle in every DIV.
// The strobe is asserted in exactly the cycles where the phase counter holds DIV-1.
module velocity_control_enable_gen
    import velocity_control_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic CLK_IN,
    input  logic reset,
    output logic enb
);

    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] phase;
    logic [CNT_W-1:0] phase_next;

    always_comb begin
        phase_next = (phase == CNT_W'(DIV - 1)) ? '0 : phase + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    // NOTE: reset is synchronous and active-low: it is only seen on a clock edge.
    always_ff @(posedge CLK_IN) begin
        if (!reset) begin
            phase <= '0;
            enb   <= 1'b0;
        end else begin
            phase <= phase_next;
            enb   <= (phase_next == CNT_W'(DIV - 1));
        end
    end

endmodule

// File: rtl/velocity_control_reset_sequencer.sv
// Controller timing for the velocity-control datapath: enable strobe plus an
// enable-aligned Reset_1 sequence with host handshake. Option: RESET_SEQ_FAULT_LATCH_EN.
module velocity_control_reset_sequencer
    import velocity_control_pkg::*;
#(
    parameter int DIV        = DIV_DEFAULT,
    parameter int HOLD_TICKS = HOLD_TICKS_DEFAULT
) (
    input  logic CLK_IN,
    input  logic reset,
    input  logic reset_req,
    input  logic fault_in,
    output logic enb_1_2000_0,
    output logic Reset_1,
    output logic req_ack,
    output logic ready
);

    localparam int HC_W = $clog2(HOLD_TICKS + 1);

    seq_state_t       state;
    logic [HC_W-1:0]  hold_cnt;

`ifndef RESET_SEQ_FAULT_LATCH_EN
    logic unused_fault;
    assign unused_fault = fault_in;
`endif

    velocity_control_enable_gen #(
        .DIV (DIV)
    ) u_enable_gen (
        .CLK_IN (CLK_IN),
        .reset  (reset),
        .enb    (enb_1_2000_0)
    );

    // Power-up lands in HOLD so the datapath always sees a full reset sequence.
    always_ff @(posedge CLK_IN) begin
        if (!reset) begin
            state    <= HOLD;
            hold_cnt <= '0;
            Reset_1  <= 1'b1;
            req_ack  <= 1'b0;
            ready    <= 1'b0;
        end else begin
            req_ack <= 1'b0;
`ifdef RESET_SEQ_FAULT_LATCH_EN
            if (fault_in) begin
                state   <= FAULT;
                Reset_1 <= 1'b1;
                ready   <= 1'b0;
            end else
`endif
            case (state)
                IDLE: begin
                    if (reset_req) begin
                        state   <= ARM;
                        req_ack <= 1'b1;
                        ready   <= 1'b0;
                    end
                end
                ARM: begin
                    if (enb_1_2000_0) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                        Reset_1  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (enb_1_2000_0) begin
                        if (hold_cnt == HC_W'(HOLD_TICKS - 1)) begin
                            state   <= IDLE;
                            Reset_1 <= 1'b0;
                            ready   <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + HC_W'(1);
                        end
                    end
                end
`ifdef RESET_SEQ_FAULT_LATCH_EN
                FAULT: begin
                    // Leaving FAULT restarts a full, enable-aligned hold.
                    if (reset_req) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                        req_ack  <= 1'b1;
                    end
                end
`endif
                default: begin
                    state    <= HOLD;
                    hold_cnt <= '0;
                    Reset_1  <= 1'b1;
                    ready    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_velocity_control_reset_sequencer.sv
// Scoreboard bench: expected output events (strobes, acks, Reset_1/ready edges)
// are queued per scenario and a negedge monitor pops and compares them.
module tb_velocity_control_reset_sequencer;

    localparam int DIV        = 10;
    localparam int HOLD_TICKS = 3;

    typedef enum logic [2:0] {
        EV_ENB, EV_ACK, EV_R1_RISE, EV_R1_FALL, EV_RDY_RISE, EV_RDY_FALL
    } ev_kind_t;

    typedef struct {
        ev_kind_t kind;
        int       cyc;
    } ev_t;

    logic CLK_IN = 1'b0;
    logic reset = 1'b0;
    logic reset_req = 1'b0;
    logic fault_in = 1'b0;
    logic enb_1_2000_0;
    logic Reset_1;
    logic req_ack;
    logic ready;

    int   cyc = 0;
    int   base = 0;
    logic mon_en = 1'b0;
    logic prev_r1 = 1'b1;
    logic prev_rdy = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    ev_t  exp_q[$];

    velocity_control_reset_sequencer #(
        .DIV        (DIV),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .CLK_IN       (CLK_IN),
        .reset        (reset),
        .reset_req    (reset_req),
        .fault_in     (fault_in),
        .enb_1_2000_0 (enb_1_2000_0),
        .Reset_1      (Reset_1),
        .req_ack      (req_ack),
        .ready        (ready)
    );

    always #5 CLK_IN = ~CLK_IN;

    always @(posedge CLK_IN) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic push_ev(input ev_kind_t kind, input int c);
        ev_t ev;
        int  key;
        int  i;
        ev.kind = kind;
        ev.cyc  = c;
        key = c * 8 + int'(kind);
        i = 0;
        while (i < exp_q.size() && (exp_q[i].cyc * 8 + int'(exp_q[i].kind)) <= key) i++;
        exp_q.insert(i, ev);
    endtask

    // Strobes at DIV-1, 2*DIV-1, ... and the power-up release at 3*DIV.
    task automatic push_boot(input int w);
        for (int c = DIV - 1; c < w; c += DIV) push_ev(EV_ENB, c);
        push_ev(EV_R1_FALL, 30);
        push_ev(EV_RDY_RISE, 30);
    endtask

    task automatic push_seq(input int ack_c, input int rise_c, input int fall_c);
        push_ev(EV_ACK, ack_c);
        push_ev(EV_RDY_FALL, ack_c);
        push_ev(EV_R1_RISE, rise_c);
        push_ev(EV_R1_FALL, fall_c);
        push_ev(EV_RDY_RISE, fall_c);
    endtask

    task automatic observe(input ev_kind_t kind, input int rel);
        ev_t ev;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none",
                     int'(kind), rel);
        end else begin
            ev = exp_q.pop_front();
            check($sformatf("event_kind@%0d", rel), int'(kind), int'(ev.kind));
            check($sformatf("event_cycle kind%0d", int'(kind)), rel, ev.cyc);
        end
    endtask

    always @(negedge CLK_IN) begin
        int rel;
        rel = cyc - base;
        if (mon_en) begin
            if (enb_1_2000_0)        observe(EV_ENB, rel);
            if (req_ack)             observe(EV_ACK, rel);
            if (Reset_1 && !prev_r1) observe(EV_R1_RISE, rel);
            if (!Reset_1 && prev_r1) observe(EV_R1_FALL, rel);
            if (ready && !prev_rdy)  observe(EV_RDY_RISE, rel);
            if (!ready && prev_rdy)  observe(EV_RDY_FALL, rel);
        end
        prev_r1  = Reset_1;
        prev_rdy = ready;
    end

    task automatic wait_cycle(input int n);
        while ((cyc - base) < n) begin
            @(posedge CLK_IN);
            #1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_enb"},     int'(enb_1_2000_0), 0);
        check({tag, "_Reset_1"}, int'(Reset_1),      1);
        check({tag, "_req_ack"}, int'(req_ack),      0);
        check({tag, "_ready"},   int'(ready),        0);
    endtask

    // Leaves the bench at cycle 0 (first cycle with reset high), monitor armed.
    task automatic do_reset();
        mon_en    = 1'b0;
        reset     = 1'b0;
        reset_req = 1'b0;
        fault_in  = 1'b0;
        repeat (2) begin
            @(posedge CLK_IN);
            #1;
        end
        check_reset_vals("reset");
        exp_q.delete();
        reset  = 1'b1;
        base   = cyc;
        mon_en = 1'b1;
    endtask

    task automatic end_window(input int w);
        wait_cycle(w);
        mon_en = 1'b0;
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-up sequence only.
        do_reset();
        push_boot(35);
        end_window(35);

        // Single request pulse in IDLE.
        do_reset();
        push_boot(95);
        push_seq(41, 50, 80);
        wait_cycle(40); reset_req = 1'b1;
        wait_cycle(41); reset_req = 1'b0;
        end_window(95);

        // Level request held: back-to-back sequences, no ack while busy.
        do_reset();
        push_boot(195);
        push_seq(41, 50, 80);
        push_seq(81, 90, 120);
        push_seq(121, 130, 160);
        push_ev(EV_ACK, 161);
        push_ev(EV_RDY_FALL, 161);
        push_ev(EV_R1_RISE, 170);
        wait_cycle(40); reset_req = 1'b1;
        wait_cycle(195); reset_req = 1'b0;
        end_window(195);

        // Request on a strobe cycle: that strobe must not start the hold.
        do_reset();
        push_boot(95);
        push_seq(40, 50, 80);
        wait_cycle(39); reset_req = 1'b1;
        wait_cycle(40); reset_req = 1'b0;
        end_window(95);

        // Reset while an ack is in flight: ack is lost.
        do_reset();
        push_boot(40);
        end_window(40);
        reset_req = 1'b1;
        reset     = 1'b0;
        @(posedge CLK_IN);
        #1;
        check_reset_vals("ack_lost");

        // Reset mid-HOLD, then a clean restart.
        do_reset();
        for (int c = DIV - 1; c < 65; c += DIV) push_ev(EV_ENB, c);
        push_ev(EV_R1_FALL, 30);
        push_ev(EV_RDY_RISE, 30);
        push_ev(EV_ACK, 41);
        push_ev(EV_RDY_FALL, 41);
        push_ev(EV_R1_RISE, 50);
        wait_cycle(40); reset_req = 1'b1;
        wait_cycle(41); reset_req = 1'b0;
        end_window(65);
        reset = 1'b0;
        @(posedge CLK_IN);
        #1;
        check_reset_vals("mid_hold");
        do_reset();
        push_boot(45);
        end_window(45);

`ifdef RESET_SEQ_FAULT_LATCH_EN
        // Fault latch: immediate Reset_1, exit only with fault clear plus request.
        do_reset();
        for (int c = DIV - 1; c < 145; c += DIV) push_ev(EV_ENB, c);
        push_ev(EV_R1_FALL, 30);
        push_ev(EV_RDY_RISE, 30);
        push_ev(EV_R1_RISE, 36);
        push_ev(EV_RDY_FALL, 36);
        push_ev(EV_ACK, 101);
        push_ev(EV_R1_FALL, 130);
        push_ev(EV_RDY_RISE, 130);
        wait_cycle(35);  fault_in = 1'b1;
        wait_cycle(60);  reset_req = 1'b1;
        wait_cycle(61);  reset_req = 1'b0;
        wait_cycle(100); fault_in = 1'b0; reset_req = 1'b1;
        wait_cycle(101); reset_req = 1'b0;
        end_window(145);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
